ibram_stream_writer: RTL
========================

# ibram_stream_writer

Parametrised second-generation input write controller for the activation path. It consumes one AXI-Stream input carrying, in order, a header, per-layer parameter words, instruction beats and the activation tensor. It serves parameter words to any number of downstream read ports, forwards instructions to the instruction buffer, and scatters each activation beat into up to MAX_KERNEL_SIZE IBRAM banks, each with its own address, in im2col order.

## Interface
- STREAM_WIDTH, 128: input stream and BRAM write data width.
- ACT_WIDTH, 8: activation element width.
- NUM_BANKS, 16: IBRAM banks; must be ≥ MAX_KERNEL_SIZE.
- MAX_IN_CHANNEL, 64; MAX_IN_SEQ, 164; MAX_KERNEL_SIZE, 5; MAX_NUM_LAYERS, 4.
- NUM_RD_PORTS, 3: parameter read ports.
- PARAM_WIDTH, 32: parameter word width.
- Derived: BEATS_MAX = ceil(MAX_IN_CHANNEL·ACT_WIDTH/STREAM_WIDTH); IBRAM_DEPTH = ceil(MAX_IN_SEQ/NUM_BANKS)·MAX_KERNEL_SIZE·BEATS_MAX; AW = clog2(IBRAM_DEPTH); LW = clog2(MAX_NUM_LAYERS+1); CW/SW/KW = clog2(MAX+1) of channel/seq/kernel.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- idata / idata_valid / idata_ready  in/in/out  STREAM_WIDTH/1/1  input stream.
- diA  out  STREAM_WIDTH  write data, shared by all banks.
- weA  out  NUM_BANKS  per-bank write enable; enaA is identical to weA.
- enaA  out  NUM_BANKS  per-bank enable.
- addrA  out  NUM_BANKS×AW  per-bank write address.
- full  in  NUM_BANKS  bank cannot accept writes.
- wr_done  out  1  one-cycle pulse with the final write.
- cfg_err  out  1  one-cycle error pulse.
- idata_instr / idata_instr_valid / idata_instr_ready  out/out/in  STREAM_WIDTH/1/1  instruction channel.
- instr_fill_done  in  1  level: instruction buffer full.
- rd_addr / rd_addr_valid / rd_addr_ready  in/in/out  NUM_RD_PORTS×LW / NUM_RD_PORTS / NUM_RD_PORTS  parameter read request.
- rd_data / rd_data_valid / rd_data_ready  out/out/in  NUM_RD_PORTS×PARAM_WIDTH / NUM_RD_PORTS / NUM_RD_PORTS  parameter read response.

## Operation
- States: IDLE, HDR, PARAM, INSTR, BRAM_WRITE.
- IDLE → HDR when idata_valid.
- HDR: accept one beat; N = idata[LW-1:0].
  - If N == 0 or N > MAX_NUM_LAYERS: pulse cfg_err and go to IDLE.
  - Otherwise clear the `loaded` flag and go to PARAM.
- PARAM: beat i stores idata[PARAM_WIDTH-1:0] into pbuf[i]. After the N-th beat, set `loaded` and go to INSTR.
- Geometry comes from pbuf[0]: C = [CW-1:0], S = [CW+SW-1:CW], K = [CW+SW+KW-1:CW+SW].
- Derived values: B = ceil(C·ACT_WIDTH/STREAM_WIDTH), O = S−K+1.
- INSTR: each accepted beat is registered onto idata_instr with idata_instr_valid = 1. Valid holds until idata_instr_ready.
- Leave INSTR when instr_fill_done && !idata_instr_valid.
  - If C == 0, K == 0, K > S, or K > MAX_KERNEL_SIZE: pulse cfg_err and go to IDLE.
  - Otherwise go to BRAM_WRITE.
- BRAM_WRITE: S·B beats, channel-beat b (0..B−1) inner and sequence s (0..S−1) outer.
  - For each k in 0..K−1 with o = s−k and 0 ≤ o < O: write bank o mod NUM_BANKS at address ((o div NUM_BANKS)·K + k)·B + b.
  - NUM_BANKS ≥ K guarantees that distinct k target distinct banks.
  - The last beat pulses wr_done and returns to IDLE.
- Parameter ports (independent, one outstanding request each):
  - rd_addr_ready[p] = loaded && !rd_data_valid[p].
  - On addr handshake: rd_data[p] = pbuf[addr], or 0 if addr ≥ N; rd_data_valid[p] rises next cycle and holds until rd_data_ready[p].
  - `loaded` persists across frames until the next valid header.

## Timing
- idata_ready is combinational:
  - HDR/PARAM: 1.
  - INSTR: !instr_fill_done && (!idata_instr_valid || idata_instr_ready).
  - BRAM_WRITE: !(|full).
  - IDLE: 0.
- Write latency is 1: diA, weA, enaA and addrA are registered from the accepted beat. weA/enaA are 0 in cycles without an accepted beat.
- full is sampled in the acceptance cycle only. A write already issued is never retracted.
- wr_done coincides with the final weA cycle.
- Reset values:
  - All outputs 0, pbuf 0, `loaded` 0, counters 0, state IDLE.
  - A reset mid-frame discards partial state; the next frame begins at HDR.
- Reads arriving during PARAM of a new frame stall (`loaded` is 0). A pending rd_data_valid survives the new header.

## Test plan
- Header N=0 → cfg_err pulse, FSM to IDLE, no pbuf change.
- N=2, params {C=20, S=18, K=3}, {x} → B=2. 2 instr beats, then instr_fill_done → the s=5, b=1 beat writes banks 5/4/3 at addr 1/3/5. s=0, b=0 writes only bank 0, addr 0. s=17 writes only bank 15, addr 4+b. wr_done is asserted on beat 36.
- full[7] asserted mid-BRAM_WRITE → idata_ready drops the same cycle, no weA until full clears, data order preserved.
- Port 0 rd_addr=1 with rd_data_ready held low 5 cycles → data = pbuf[1] held valid, rd_addr_ready[0] low throughout. Meanwhile port 2 rd_addr=3 returns 0.
- idata_instr_ready toggling 1/0 → every instruction beat is forwarded exactly once, in order.
- rst pulsed during PARAM → all outputs 0. A following complete frame behaves as the second scenario.

Source files
------------

// File: rtl/ibram_stream_writer.sv
// ibram_stream_writer: stream splitter feeding parameter read ports, an instruction channel, and banked im2col IBRAM writes
// Ports: clk/rst (async active-high); idata* input stream; diA/weA/enaA/addrA banked write port with per-bank full;
// wr_done/cfg_err pulses; idata_instr* instruction channel gated by instr_fill_done; rd_addr*/rd_data* parameter read ports.
module ibram_stream_writer #(
  parameter int STREAM_WIDTH = 128,
  parameter int ACT_WIDTH = 8,
  parameter int NUM_BANKS = 16,
  parameter int MAX_IN_CHANNEL = 64,
  parameter int MAX_IN_SEQ = 164,
  parameter int MAX_KERNEL_SIZE = 5,
  parameter int MAX_NUM_LAYERS = 4,
  parameter int NUM_RD_PORTS = 3,
  parameter int PARAM_WIDTH = 32,
  localparam int BEATS_MAX = (MAX_IN_CHANNEL * ACT_WIDTH + STREAM_WIDTH - 1) / STREAM_WIDTH,
  localparam int IBRAM_DEPTH = ((MAX_IN_SEQ + NUM_BANKS - 1) / NUM_BANKS) * MAX_KERNEL_SIZE * BEATS_MAX,
  localparam int AW = $clog2(IBRAM_DEPTH),
  localparam int LW = $clog2(MAX_NUM_LAYERS + 1),
  localparam int CW = $clog2(MAX_IN_CHANNEL + 1),
  localparam int SW = $clog2(MAX_IN_SEQ + 1),
  localparam int KW = $clog2(MAX_KERNEL_SIZE + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [STREAM_WIDTH-1:0]             idata,
  input  logic                                idata_valid,
  output logic                                idata_ready,
  output logic [STREAM_WIDTH-1:0]             diA,
  output logic [NUM_BANKS-1:0]                weA,
  output logic [NUM_BANKS-1:0]                enaA,
  output logic [NUM_BANKS*AW-1:0]             addrA,
  input  logic [NUM_BANKS-1:0]                full,
  output logic                                wr_done,
  output logic                                cfg_err,
  output logic [STREAM_WIDTH-1:0]             idata_instr,
  output logic                                idata_instr_valid,
  input  logic                                idata_instr_ready,
  input  logic                                instr_fill_done,
  input  logic [NUM_RD_PORTS*LW-1:0]          rd_addr,
  input  logic [NUM_RD_PORTS-1:0]             rd_addr_valid,
  output logic [NUM_RD_PORTS-1:0]             rd_addr_ready,
  output logic [NUM_RD_PORTS*PARAM_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]             rd_data_valid,
  input  logic [NUM_RD_PORTS-1:0]             rd_data_ready
);
  localparam int BW = $clog2(BEATS_MAX + 1);
  localparam int NBW = $clog2(NUM_BANKS);
  typedef enum logic [2:0] {IDLE, HDR, PARAM, INSTR, BRAM_WRITE} state_t;
  state_t r_state, w_next;
  logic [PARAM_WIDTH-1:0] r_pbuf [2**LW];
  logic [LW-1:0] r_n, r_pidx, w_hdr_n;
  logic r_loaded;
  logic [SW-1:0] r_s, w_s;
  logic [BW-1:0] r_b, w_bn;
  logic [CW-1:0] w_c;
  logic [KW-1:0] w_k;
  logic w_acc, w_hdr_bad, w_geo_bad, w_instr_exit, w_last, w_b_wrap;
  logic [NUM_BANKS-1:0] w_we;
  logic [AW-1:0] w_addr [NUM_BANKS];
  assign w_c = r_pbuf[0][CW-1:0];
  assign w_s = r_pbuf[0][CW+SW-1:CW];
  assign w_k = r_pbuf[0][CW+SW+KW-1:CW+SW];
  assign w_bn = BW'((int'(w_c) * ACT_WIDTH + STREAM_WIDTH - 1) / STREAM_WIDTH);
  assign w_hdr_n = idata[LW-1:0];
  assign w_hdr_bad = w_hdr_n == '0 || int'(w_hdr_n) > MAX_NUM_LAYERS;
  assign w_geo_bad = w_c == '0 || w_k == '0 || int'(w_k) > int'(w_s) || int'(w_k) > MAX_KERNEL_SIZE;
  assign w_acc = idata_valid && idata_ready;
  assign w_instr_exit = r_state == INSTR && instr_fill_done && !idata_instr_valid;
  assign w_b_wrap = r_b == w_bn - BW'(1);
  assign w_last = r_s == w_s - SW'(1) && w_b_wrap;
  assign enaA = weA;
  assign rd_addr_ready = {NUM_RD_PORTS{r_loaded}} & ~rd_data_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = idata_valid ? HDR : IDLE;
      HDR: if (idata_valid) w_next = w_hdr_bad ? IDLE : PARAM;
      PARAM: if (idata_valid && r_pidx == r_n - LW'(1)) w_next = INSTR;
      INSTR: if (w_instr_exit) w_next = w_geo_bad ? IDLE : BRAM_WRITE;
      BRAM_WRITE: if (w_acc && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb
    idata_ready = (r_state == HDR || r_state == PARAM) ? 1'b1 :
                  r_state == INSTR ? (!instr_fill_done && (!idata_instr_valid || idata_instr_ready)) :
                  r_state == BRAM_WRITE ? !(|full) : 1'b0;
  // Sequence position s feeds output rows o = s-k; each valid tap lands in a distinct bank.
  always_comb begin
    w_we = '0;
    for (int n = 0; n < NUM_BANKS; n++) w_addr[n] = '0;
    for (int k = 0; k < MAX_KERNEL_SIZE; k++)
      if (k < int'(w_k) && int'(r_s) >= k && int'(r_s) - k <= int'(w_s) - int'(w_k)) begin
        w_we[NBW'((int'(r_s) - k) % NUM_BANKS)] = 1'b1;
        w_addr[NBW'((int'(r_s) - k) % NUM_BANKS)] =
          AW'((((int'(r_s) - k) / NUM_BANKS) * int'(w_k) + k) * int'(w_bn) + int'(r_b));
      end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**LW; i++) r_pbuf[i] <= '0;
      r_n <= '0;
      r_pidx <= '0;
      r_loaded <= 1'b0;
      r_s <= '0;
      r_b <= '0;
      diA <= '0;
      weA <= '0;
      addrA <= '0;
      wr_done <= 1'b0;
      cfg_err <= 1'b0;
      idata_instr <= '0;
      idata_instr_valid <= 1'b0;
      rd_data <= '0;
      rd_data_valid <= '0;
    end else begin
      weA <= '0;
      wr_done <= 1'b0;
      cfg_err <= 1'b0;
      if (r_state == HDR && idata_valid) begin
        if (w_hdr_bad) cfg_err <= 1'b1;
        else begin
          r_n <= w_hdr_n;
          r_pidx <= '0;
          r_loaded <= 1'b0;
        end
      end
      if (r_state == PARAM && idata_valid) begin
        r_pbuf[r_pidx] <= idata[PARAM_WIDTH-1:0];
        r_pidx <= r_pidx + LW'(1);
        if (r_pidx == r_n - LW'(1)) r_loaded <= 1'b1;
      end
      if (r_state == INSTR && w_acc) begin
        idata_instr <= idata;
        idata_instr_valid <= 1'b1;
      end else if (idata_instr_ready) idata_instr_valid <= 1'b0;
      if (w_instr_exit) begin
        cfg_err <= w_geo_bad;
        r_s <= '0;
        r_b <= '0;
      end
      if (r_state == BRAM_WRITE && w_acc) begin
        diA <= idata;
        weA <= w_we;
        for (int n = 0; n < NUM_BANKS; n++) addrA[n*AW +: AW] <= w_addr[n];
        wr_done <= w_last;
        r_b <= w_b_wrap ? '0 : r_b + BW'(1);
        if (w_b_wrap) r_s <= r_s + SW'(1);
      end
      for (int p = 0; p < NUM_RD_PORTS; p++)
        if (rd_addr_valid[p] && rd_addr_ready[p]) begin
          rd_data[p*PARAM_WIDTH +: PARAM_WIDTH] <= rd_addr[p*LW +: LW] < r_n ? r_pbuf[rd_addr[p*LW +: LW]] : '0;
          rd_data_valid[p] <= 1'b1;
        end else if (rd_data_ready[p]) rd_data_valid[p] <= 1'b0;
    end
  end
endmodule
